conv_window_mac: RTL
====================

Name: conv_window_mac

Overview:
- Downstream consumer of the CNN line/window buffer.
- Takes each KERNEL_SIZE x KERNEL_SIZE window of 32-bit words, does a signed multiply-accumulate against a locally stored weight set, adds a bias, and emits one 32-bit result per window.
- Results go out on a valid/ready stream to the output writer.
- Back-pressure is returned to the buffer through window_stall. The end of a layer is signalled by a one-cycle done pulse after the pipeline drains.

Parameters:
- KERNEL_SIZE, 3, max kernel edge; the window holds WINDOW_SIZE = KERNEL_SIZE*KERNEL_SIZE words.
- DATA_W, 32, width of the data, weight, bias and result words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a layer; honoured only in IDLE
- w_we  in  1  weight write strobe; ignored unless IDLE
- w_addr  in  $clog2(WINDOW_SIZE)  weight index, row-major (i*KERNEL_SIZE+j)
- w_wdata  in  DATA_W  weight value, signed
- bias_we  in  1  bias write strobe; ignored unless IDLE
- bias_wdata  in  DATA_W  bias value, signed
- window  in  WINDOW_SIZE*DATA_W  window word i*KERNEL_SIZE+j at bits [(i*K+j)*32 +: 32]
- window_valid  in  1  window word is valid
- window_finish  in  1  level; last window has been issued
- window_stall  out  1  back-pressure to the buffer
- out_valid  out  1  result valid
- out_data  out  DATA_W  result
- out_ready  in  1  consumer accepts the result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at the end of a layer

Behaviour:
- Reset state: IDLE. All pipeline valid bits 0; out_valid=0, out_data=0, done=0, busy=0, window_stall=0.
- Reset does not clear the weight and bias registers.
- Reset asserted mid-layer aborts the layer at once: no done pulse, and in-flight results are discarded.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN in the first cycle window_finish=1. A window that is valid in that same cycle is still accepted.
  - DRAIN -> IDLE when all stage-valid bits and out_valid are 0. done pulses in that transition cycle.
  - start is ignored outside IDLE.
- Global advance: adv = ~(out_valid & ~out_ready). window_stall = ~adv while in RUN; window_stall = 0 in IDLE.
- Window accept: acc = state==RUN & window_valid & adv. The buffer holds window/window_valid while stalled.
- Pipeline: three stages, all advancing on adv. Latency from accepted window to out_valid is exactly 3 cycles with out_ready held high. Throughput is 1 window per cycle.
  - S1: p[k] = low DATA_W bits of signed window[k]*weight[k], registered.
  - S2: row sums r[i] = sum over j of p[i*K+j], registered.
  - S3: out_data = sum of r[i] + bias. out_valid is set when the S2 valid bit advances.
- Arithmetic: all adds wrap modulo 2^DATA_W; no saturation.
- Zeroed window positions (unused rows/columns) contribute 0 naturally; no kernel-size input is needed.
- out_valid/out_data hold stable while out_valid & ~out_ready.
- Simultaneous events:
  - A weight/bias write in the same cycle as start is still written, because the state is IDLE that cycle.
  - If window_finish is already high at start, the next cycle goes RUN -> DRAIN, accepting at most one window.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: S3 output is clamped, out_data = (sum[DATA_W-1] ? 0 : sum). Latency is unchanged.
- Undefined: raw wrapped sum.

Decomposition:
- Shared package/header (alongside CNNConfig.vh):
  - WINDOW_SIZE and DATA_W derivation.
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One natural sub-module, mac_adder_tree: a parametric registered row-sum stage (KERNEL_SIZE inputs -> 1 output), instantiated KERNEL_SIZE times in S2.

Test Plan:
- Identity: weights all 0 except w[4]=1, bias=0; windows with centre word 7, -3, 100, out_ready=1 -> out_data 7, -3 (0xFFFFFFFD), 100 on cycles N+3, N+4, N+5.
- Full sum: weights all 2, bias=5; window all 1s -> out_data 23. Window with word value = its index 0..8 -> 77.
- Back-pressure: out_ready=0 for 4 cycles while 5 windows are offered -> window_stall rises once out_valid=1 and S1/S2 are full; no result lost or duplicated; results in order after out_ready=1.
- Finish: window_finish and the last window_valid in the same cycle -> that window's result emerges; done pulses exactly once, in the cycle the pipe is empty; busy falls with it.
- Gated writes: w_we during RUN with w_addr=4, data=99 -> weight unchanged and results unaffected. Same write in IDLE -> takes effect on the next layer.
- CONV_RELU_EN: weights all -1, bias 0, window all 1s -> out_data 0 with the macro defined, 0xFFFFFFF7 without. A reset pulse mid-RUN -> out_valid=0 next cycle and no done pulse.

Source files
------------

// File: rtl/conv_window_mac_pkg.sv
// Shared configuration for the convolution window MAC: default geometry,
// derived window size and the layer FSM encoding.
package conv_window_mac_pkg;

  localparam int CWM_KERNEL_SIZE = 3;
  localparam int CWM_DATA_W      = 32;
  localparam int CWM_WINDOW_SIZE = CWM_KERNEL_SIZE * CWM_KERNEL_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int win_size(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_window_mac_mac_adder_tree.sv
// Registered row-sum stage: adds N words of width W (wrapping) and holds the
// result while en is low.
module mac_adder_tree #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [N*W-1:0]   in_flat,
  output logic [W-1:0]     sum_q
);

  logic [W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (en) begin
      sum_d = '0;
      for (int j = 0; j < N; j++) begin
        sum_d = sum_d + in_flat[j*W +: W];
      end
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

endmodule

// File: rtl/conv_window_mac.sv
// Window multiply-accumulate: 3-stage pipeline (products, row sums, total+bias)
// behind a valid/ready output. Optional output clamp with macro CONV_RELU_EN.
module conv_window_mac
  import conv_window_mac_pkg::*;
#(
  parameter  int KERNEL_SIZE = CWM_KERNEL_SIZE,
  parameter  int DATA_W      = CWM_DATA_W,
  localparam int WINDOW_SIZE = win_size(KERNEL_SIZE),
  localparam int ADDR_W      = $clog2(WINDOW_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          w_we,
  input  logic [ADDR_W-1:0]             w_addr,
  input  logic [DATA_W-1:0]             w_wdata,
  input  logic                          bias_we,
  input  logic [DATA_W-1:0]             bias_wdata,
  input  logic [WINDOW_SIZE*DATA_W-1:0] window,
  input  logic                          window_valid,
  input  logic                          window_finish,
  output logic                          window_stall,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WINDOW_SIZE - 1);

  state_e                          state_q, state_d;
  logic [DATA_W-1:0]               w_q [WINDOW_SIZE];
  logic [DATA_W-1:0]               w_d [WINDOW_SIZE];
  logic [DATA_W-1:0]               bias_q, bias_d;
  logic [WINDOW_SIZE*DATA_W-1:0]   p_q, p_d;
  logic [DATA_W-1:0]               r_q [KERNEL_SIZE];
  logic                            s1_valid_q, s1_valid_d;
  logic                            s2_valid_q, s2_valid_d;
  logic                            out_valid_q, out_valid_d;
  logic [DATA_W-1:0]               out_data_q, out_data_d;
  logic [DATA_W-1:0]               sum_s, result_s;
  logic                            adv, acc;

  assign adv          = ~(out_valid_q & ~out_ready);
  assign acc          = (state_q == RUN) & window_valid & adv;
  assign window_stall = (state_q == RUN) & ~adv;
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

  // Layer FSM; done is suppressed while reset is asserted so an abort never pulses it.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (window_finish) state_d = DRAIN;
        else               state_d = RUN;
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q && !out_valid_q) begin
          state_d = IDLE;
          done    = ~rst;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight and bias writes are only honoured between layers.
  always_comb begin
    w_d    = w_q;
    bias_d = bias_q;
    if (state_q == IDLE) begin
      if (w_we && (w_addr <= LAST_ADDR)) w_d[w_addr] = w_wdata;
      else                               w_d = w_q;
      if (bias_we) bias_d = bias_wdata;
      else         bias_d = bias_q;
    end else begin
      w_d    = w_q;
      bias_d = bias_q;
    end
  end

  // S1: per-position products, low DATA_W bits only.
  always_comb begin
    p_d = p_q;
    if (adv) begin
      for (int k = 0; k < WINDOW_SIZE; k++) begin
        p_d[k*DATA_W +: DATA_W] =
          DATA_W'($signed(window[k*DATA_W +: DATA_W]) * $signed(w_q[k]));
      end
    end else begin
      p_d = p_q;
    end
  end

  // S3: total of row sums plus bias.
  always_comb begin
    sum_s = bias_q;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      sum_s = sum_s + r_q[i];
    end
`ifdef CONV_RELU_EN
    result_s = sum_s[DATA_W-1] ? '0 : sum_s;
`else
    result_s = sum_s;
`endif
  end

  // Stage valid bits and output register all move together on adv.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      s1_valid_d  = acc;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (s2_valid_q) out_data_d = result_s;
      else            out_data_d = out_data_q;
    end else begin
      out_data_d = out_data_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
      mac_adder_tree #(
        .N (KERNEL_SIZE),
        .W (DATA_W)
      ) u_row (
        .clk     (clk),
        .en      (adv),
        .in_flat (p_q[gi*KERNEL_SIZE*DATA_W +: KERNEL_SIZE*DATA_W]),
        .sum_q   (r_q[gi])
      );
    end
  endgenerate

  // Control and output state; reset aborts any layer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Coefficients survive reset; product register needs no reset.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    bias_q <= bias_d;
    p_q    <= p_d;
  end

endmodule
